// File: rtl/ivs_rst_seq.sv
// Reset sequencer: one async reset in, NCH staged channel resets and divided
// clock-enable strobes out, with a software-triggered re-sequence from DONE.
module ivs_rst_seq #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic [NCH*CNT_W-1:0] cfg_dly,
  input  logic [NCH*DIV_W-1:0] cfg_div,
  input  logic                 sw_rst_req,
  output logic [NCH-1:0]       ch_rst_n,
  output logic [NCH-1:0]       ch_clken,
  output logic                 seq_done
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NCH*CNT_W-1:0] dly_q;
  logic [NCH*DIV_W-1:0] div_q;
  logic [NCH*DIV_W-1:0] dcnt_q, dcnt_d;
  logic [NCH-1:0]       rst_n_q, rst_n_d;
  logic [NCH-1:0]       clken_q, clken_d;
  logic                 done_q, done_d;
  logic                 dly_ld;
  logic                 restart;
  logic [NCH-1:0]       rel;

  // Release sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    dly_ld  = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_RST: begin
        // Move on the same edge the synchronizer output rises
        if (sync_q[0] && !sync_q[1]) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
          dly_ld  = 1'b1;
        end
      end
      ST_COUNT: begin
        for (int i = 0; i < NCH; i++) begin
          if (cnt_q == dly_q[i*CNT_W +: CNT_W]) rst_n_d[i] = 1'b1;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        if (&rst_n_d) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          restart = 1'b1;
          rst_n_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          dly_ld  = 1'b1;
          state_d = ST_COUNT;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  assign rel = rst_n_d & ~rst_n_q;

  // Per-channel enable dividers
  always_comb begin
    dcnt_d  = dcnt_q;
    clken_d = clken_q;
    for (int i = 0; i < NCH; i++) begin
      if (restart || !rst_n_q[i]) begin
        dcnt_d[i*DIV_W +: DIV_W] = '0;
        clken_d[i]               = 1'b0;
      end else begin
        clken_d[i] = (dcnt_q[i*DIV_W +: DIV_W] == div_q[i*DIV_W +: DIV_W]);
        dcnt_d[i*DIV_W +: DIV_W] = clken_d[i] ? '0
                                              : dcnt_q[i*DIV_W +: DIV_W] + DIV_ONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_RST;
      sync_q  <= '0;
      cnt_q   <= '0;
      rst_n_q <= '0;
      clken_q <= '0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], 1'b1};
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      clken_q <= clken_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Configuration snapshots; only read after being loaded
  always_ff @(posedge aclk) begin
    if (dly_ld) dly_q <= cfg_dly;
    for (int i = 0; i < NCH; i++) begin
      if (rel[i]) div_q[i*DIV_W +: DIV_W] <= cfg_div[i*DIV_W +: DIV_W];
    end
  end

  assign ch_rst_n = rst_n_q;
  assign ch_clken = clken_q;
  assign seq_done = done_q;

endmodule

// File: tb/tb_ivs_rst_seq.sv
// Scoreboard bench for ivs_rst_seq: directed sequences push expected output
// snapshots tagged with a cycle; a negedge monitor pops and compares them.
module tb_ivs_rst_seq;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        arst_n, arst4_n;
  logic        sw_rst_req, sw4;
  logic [31:0] cfg_dly;
  logic [15:0] cfg_div;
  logic [15:0] cfg_dly4, cfg_div4;
  logic [3:0]  ch_rst_n, ch_clken, ch_rst_n4, ch_clken4;
  logic        seq_done, seq_done4;

  ivs_rst_seq #(.NCH(4), .CNT_W(8), .DIV_W(4)) u_dut (
    .aclk(aclk), .arst_n(arst_n), .cfg_dly(cfg_dly), .cfg_div(cfg_div),
    .sw_rst_req(sw_rst_req), .ch_rst_n(ch_rst_n), .ch_clken(ch_clken),
    .seq_done(seq_done)
  );

  ivs_rst_seq #(.NCH(4), .CNT_W(4), .DIV_W(4)) u_dut_c4 (
    .aclk(aclk), .arst_n(arst4_n), .cfg_dly(cfg_dly4), .cfg_div(cfg_div4),
    .sw_rst_req(sw4), .ch_rst_n(ch_rst_n4), .ch_clken(ch_clken4),
    .seq_done(seq_done4)
  );

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] rst;
    logic [3:0] clk;
    logic       done;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   end_flush = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin : monitor
    exp_t       e;
    logic [8:0] act;
    logic [8:0] want;
    while (sbq.size() > 0 && (end_flush || sbq[0].cyc <= cyc)) begin
      e    = sbq.pop_front();
      act  = (e.sel == 0) ? {ch_rst_n, ch_clken, seq_done}
                          : {ch_rst_n4, ch_clken4, seq_done4};
      want = {e.rst, e.clk, e.done};
      n_chk++;
      if (end_flush || e.cyc != cyc || act !== want) begin
        n_fail++;
        $display("FAIL %s: got rst_n=%b clken=%b done=%b at cycle %0d, expected rst_n=%b clken=%b done=%b at cycle %0d",
                 e.name, act[8:5], act[4:1], act[0], cyc, e.rst, e.clk, e.done, e.cyc);
      end
    end
  end

  task automatic push(input int k, input int sel, input logic [3:0] r,
                      input logic [3:0] c, input logic d, input string nm);
    exp_t e;
    e.cyc  = base + k;
    e.sel  = sel;
    e.rst  = r;
    e.clk  = c;
    e.done = d;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic chk_zero(input int sel, input string nm);
    logic [8:0] act;
    act = (sel == 0) ? {ch_rst_n, ch_clken, seq_done}
                     : {ch_rst_n4, ch_clken4, seq_done4};
    n_chk++;
    if (act !== 9'b0) begin
      n_fail++;
      $display("FAIL %s: got rst_n=%b clken=%b done=%b at cycle %0d, expected all zero",
               nm, act[8:5], act[4:1], act[0], cyc);
    end
  endtask

  task automatic wait_to(input int k);
    int guard;
    guard = 0;
    while (cyc < base + k) begin
      @(negedge aclk);
      guard++;
      if (guard > 1000) begin
        n_fail++;
        $display("FAIL wait_to: cycle %0d not reached, stuck at cycle %0d", base + k, cyc);
        break;
      end
    end
  endtask

  initial begin
    arst_n     = 1'b0;
    arst4_n    = 1'b0;
    sw_rst_req = 1'b0;
    sw4        = 1'b0;
    // channel 0..3 delays 3,0,7,3 and divides 2,0,1,3
    cfg_dly    = {8'd3, 8'd7, 8'd0, 8'd3};
    cfg_div    = {4'd3, 4'd1, 4'd0, 4'd2};
    cfg_dly4   = 16'hFFFF;
    cfg_div4   = 16'h0000;

    @(negedge aclk);
    chk_zero(0, "reset_state");
    chk_zero(1, "reset_state_c4");
    base = cyc;
    for (int k = 1; k <= 3; k++) push(k, 0, 4'b0000, 4'b0000, 1'b0, "reset_hold");
    wait_to(3);

    // Power-on sequence
    arst_n = 1'b1;
    base = cyc;
    push(1,  0, 4'b0000, 4'b0000, 1'b0, "pwr_e1");
    push(2,  0, 4'b0000, 4'b0000, 1'b0, "pwr_e2");
    push(3,  0, 4'b0010, 4'b0000, 1'b0, "pwr_e3_ch1_rel");
    push(4,  0, 4'b0010, 4'b0010, 1'b0, "pwr_e4_ch1_en");
    push(5,  0, 4'b0010, 4'b0010, 1'b0, "pwr_e5");
    push(6,  0, 4'b1011, 4'b0010, 1'b0, "pwr_e6_ch0_ch3_rel");
    push(7,  0, 4'b1011, 4'b0010, 1'b0, "pwr_e7");
    push(8,  0, 4'b1011, 4'b0010, 1'b0, "pwr_e8");
    push(9,  0, 4'b1011, 4'b0011, 1'b0, "pwr_e9_ch0_pulse");
    push(10, 0, 4'b1111, 4'b1010, 1'b1, "pwr_e10_done");
    push(11, 0, 4'b1111, 4'b0010, 1'b1, "pwr_e11");
    push(12, 0, 4'b1111, 4'b0111, 1'b1, "pwr_e12");
    push(13, 0, 4'b1111, 4'b0010, 1'b1, "pwr_e13");
    push(14, 0, 4'b1111, 4'b1110, 1'b1, "pwr_e14");
    push(15, 0, 4'b1111, 4'b0011, 1'b1, "pwr_e15");
    wait_to(15);

    // One-cycle software re-sequence with new delays of 1
    base = cyc;
    cfg_dly    = {8'd1, 8'd1, 8'd1, 8'd1};
    cfg_div    = 16'h0000;
    sw_rst_req = 1'b1;
    push(1, 0, 4'b0000, 4'b0000, 1'b0, "sw_drop");
    push(2, 0, 4'b0000, 4'b0000, 1'b0, "sw_s1");
    push(3, 0, 4'b1111, 4'b0000, 1'b1, "sw_s2_rel");
    push(4, 0, 4'b1111, 4'b1111, 1'b1, "sw_s3_en");
    wait_to(1);
    sw_rst_req = 1'b0;
    wait_to(4);

    // Request held through COUNT retriggers on the first DONE edge
    base = cyc;
    cfg_dly    = {8'd2, 8'd2, 8'd2, 8'd2};
    sw_rst_req = 1'b1;
    push(1, 0, 4'b0000, 4'b0000, 1'b0, "hold_drop");
    push(2, 0, 4'b0000, 4'b0000, 1'b0, "hold_k2");
    push(3, 0, 4'b0000, 4'b0000, 1'b0, "hold_k3");
    push(4, 0, 4'b1111, 4'b0000, 1'b1, "hold_rel");
    push(5, 0, 4'b0000, 4'b0000, 1'b0, "hold_retrigger");
    push(6, 0, 4'b0000, 4'b0000, 1'b0, "hold_k6");
    push(7, 0, 4'b0000, 4'b0000, 1'b0, "hold_k7");
    push(8, 0, 4'b1111, 4'b0000, 1'b1, "hold_rel2");
    push(9, 0, 4'b1111, 4'b1111, 1'b1, "hold_en");
    wait_to(5);
    sw_rst_req = 1'b0;
    wait_to(9);

    // Async reset between channel releases, then power-on timing again
    base = cyc;
    cfg_dly    = {8'd3, 8'd7, 8'd0, 8'd3};
    cfg_div    = {4'd3, 4'd1, 4'd0, 4'd2};
    sw_rst_req = 1'b1;
    push(1, 0, 4'b0000, 4'b0000, 1'b0, "mid_drop");
    push(2, 0, 4'b0010, 4'b0000, 1'b0, "mid_ch1_rel");
    push(5, 0, 4'b1011, 4'b0010, 1'b0, "mid_ch0_ch3_rel");
    push(6, 0, 4'b0000, 4'b0000, 1'b0, "mid_async_clear");
    wait_to(1);
    sw_rst_req = 1'b0;
    wait_to(5);
    @(posedge aclk);
    #1 arst_n = 1'b0;
    #1 chk_zero(0, "mid_async_immediate");
    @(negedge aclk);
    @(negedge aclk);
    arst_n = 1'b1;
    base = cyc;
    push(1,  0, 4'b0000, 4'b0000, 1'b0, "re_e1");
    push(2,  0, 4'b0000, 4'b0000, 1'b0, "re_e2");
    push(3,  0, 4'b0010, 4'b0000, 1'b0, "re_e3");
    push(4,  0, 4'b0010, 4'b0010, 1'b0, "re_e4");
    push(6,  0, 4'b1011, 4'b0010, 1'b0, "re_e6");
    push(9,  0, 4'b1011, 4'b0011, 1'b0, "re_e9");
    push(10, 0, 4'b1111, 4'b1010, 1'b1, "re_e10_done");
    wait_to(10);

    // 4-bit counter at maximum delay; later cfg_dly change must be ignored
    arst4_n = 1'b1;
    base = cyc;
    push(2,  1, 4'b0000, 4'b0000, 1'b0, "c4_e2");
    push(4,  1, 4'b0000, 4'b0000, 1'b0, "c4_e4_latched");
    push(17, 1, 4'b0000, 4'b0000, 1'b0, "c4_e17");
    push(18, 1, 4'b1111, 4'b0000, 1'b1, "c4_e18_rel");
    push(19, 1, 4'b1111, 4'b1111, 1'b1, "c4_e19_en");
    wait_to(3);
    cfg_dly4 = 16'h1111;
    wait_to(19);

    repeat (2) @(negedge aclk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations not consumed at cycle %0d", sbq.size(), cyc);
    end
    end_flush = 1'b1;
    @(negedge aclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ivs_rst_seq.md
# ivs_rst_seq

Parametrised reset sequencer and clock-enable generator for the simulation and bring-up environment. From a single clock and one asynchronous reset it produces NCH staged, synchronously released channel resets and NCH divided clock-enable strobes. It supports a software-triggered re-sequence. It sits between the top-level clock/reset source and the per-subsystem reset/enable inputs, replacing fixed per-domain reset delays with configurable ones.

## Interface
Parameters:
- NCH, 4, number of reset/enable channels (1..16)
- CNT_W, 8, width of each per-channel release delay
- DIV_W, 4, width of each per-channel clock-enable divide value

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (aclk, arst_n).
- aclk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- cfg_dly  in  NCH*CNT_W  per-channel release delay in cycles; channel i uses bits [i*CNT_W +: CNT_W]
- cfg_div  in  NCH*DIV_W  per-channel enable divide value d; enable period is d+1 cycles
- sw_rst_req  in  1  level-sampled request to re-run the sequence
- ch_rst_n  out  NCH  per-channel active-low reset
- ch_clken  out  NCH  per-channel clock-enable strobe
- seq_done  out  1  high once all channels are released

## Operation
- State machine states:
  - RST: arst_n low, or synchronizer not yet flushed.
  - COUNT: release counter running.
  - DONE: all channels released.
- arst_n low (any state, any time): asynchronously forces state=RST, release counter=0, 2-flop synchronizer=0, every divider=0. Outputs go to ch_rst_n=0, ch_clken=0, seq_done=0.
- RST -> COUNT: when the 2-flop synchronizer output goes high, 2 edges after arst_n deasserts. On entry, cnt=0 and cfg_dly is latched into dly_q.
- COUNT:
  - Each edge: for every channel with cnt==dly_q[i], set ch_rst_n[i]=1.
  - cnt increments each edge and saturates at 2^CNT_W-1.
  - When all bits of ch_rst_n are 1: go to DONE and set seq_done=1 on the same edge.
- DONE: if sw_rst_req is 1 on an edge, then on that edge:
  - ch_rst_n=0, ch_clken=0, seq_done=0, all dividers cleared.
  - cnt=0, cfg_dly re-latched.
  - state=COUNT.
- sw_rst_req is ignored in RST and COUNT.
- Channels with equal delays release on the same edge.
- Per-channel enable (channel i, divider div_i):
  - While ch_rst_n[i]=0: div_i=0 and ch_clken[i]=0.
  - On the release edge, cfg_div[i] is latched into div_q[i].
  - After release: div_i counts 0..div_q[i] and wraps.
  - ch_clken[i] is registered and is 1 in the cycle following an edge where div_i==div_q[i].
  - div_q=0 gives ch_clken[i] constant 1 from the edge after release.
- cfg_div changes after release have no effect until the next sequence.
- cfg_dly changes during COUNT have no effect until the next sequence.

## Timing
- All outputs reset to 0 asynchronously.
- All outputs are registered and change only on aclk rising edges (reset excepted).
- Power-on, counting rising edges E1, E2, ... after arst_n deasserts:
  - COUNT is entered at E2.
  - Channel i releases at E(3+dly_i).
  - seq_done rises at the release edge of the last channel.
- Software re-sequence, with request sampled at edge S:
  - Channels drop at S.
  - Channel i releases at S+1+dly_i.
- Enable strobes, with channel released at edge R:
  - First ch_clken[i] high pulse starts at R+1+div_i.
  - Pulses repeat every div_i+1 edges, each one cycle wide (unless div_i=0).
- arst_n asserted mid-COUNT or mid-DONE: immediate return to RST; full synchronizer latency applies again on release.
- Maximum delay 2^CNT_W-1 is always reached, because the counter saturates rather than wrapping.

## Test plan
- NCH=4, cfg_dly={3,0,7,3}, arst_n released before E1 -> ch_rst_n[1] rises at E3, [0] and [3] at E6, [2] at E10; seq_done at E10.
- cfg_div for channel 0 = 2, released at E6 -> ch_clken[0] high at E9, E12, E15 (one cycle each); cfg_div=0 channel -> ch_clken constantly 1 from the edge after its release.
- In DONE, sw_rst_req pulsed one cycle at edge S with cfg_dly changed to {1,1,1,1} -> all ch_rst_n 0 and seq_done 0 at S; all channels release at S+2; seq_done at S+2.
- sw_rst_req held high during COUNT -> no effect until DONE; then re-sequence triggers on the first DONE edge where the request is sampled.
- arst_n pulsed low mid-COUNT, between two channel releases -> all outputs 0 immediately; after release, timing restarts exactly as at power-on (first release at E3+dly).
- CNT_W=4, cfg_dly all 15, cfg_dly changed during COUNT -> releases at E18 using the latched values; counter holds at 15 with no wrap.
